sync_pulse_tracker: RTL

//  Receive-side consumer of the periodic sync strobe (NOM_WIDTH-cycle high pulse every NOM_PERIOD clocks).
//  - Detects rising edges and measures pulse period and width.
//  - Declares lock after LOCK_COUNT consecutive in-tolerance periods; flags missing or malformed pulses.
//  - Sits beside the sync generator, on the same clk; downstream logic gates on locked/sync_rise.

---
 rtl/sync_pulse_tracker_if.sv | 51 +++++
 rtl/sync_pulse_tracker.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_pulse_tracker_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sync_pulse_tracker_if                                           |
// | Purpose  : Signal bundle between a sync strobe source / status consumer    |
// |            and the sync_pulse_tracker.                                     |
// | Signals  : sync_in   strobe into the tracker                              |
// |            err_clr   1-cycle clear of miss_err / err_cnt                   |
// |            sync_rise 1-cycle strobe per detected rising edge               |
// |            locked    tracker is in LOCKED                                  |
// |            period    last measured rise-to-rise spacing                    |
// |            width     last measured high time                               |
// |            miss_err  sticky fault flag                                     |
// |            err_cnt   saturating fault count                                |
// | Modports : master = strobe source / status reader, slave = tracker         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface sync_pulse_tracker_if #(
  parameter int CNT_W = 16
);
  logic             sync_in;
  logic             err_clr;
  logic             sync_rise;
  logic             locked;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] width;
  logic             miss_err;
  logic [7:0]       err_cnt;

  modport master (
    output sync_in,
    output err_clr,
    input  sync_rise,
    input  locked,
    input  period,
    input  width,
    input  miss_err,
    input  err_cnt
  );

  modport slave (
    input  sync_in,
    input  err_clr,
    output sync_rise,
    output locked,
    output period,
    output width,
    output miss_err,
    output err_cnt
  );
endinterface
`default_nettype wire

// File: rtl/sync_pulse_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sync_pulse_tracker                                              |
// | Purpose  : Receive-side tracker for a periodic sync strobe. Detects rising |
// |            edges, measures period and high time, declares lock after      |
// |            LOCK_COUNT consecutive in-tolerance periods and flags missing  |
// |            or malformed pulses while locked.                               |
// | Ports    : clk  system clock, everything on posedge                        |
// |            rst  synchronous reset, active-high, highest priority           |
// |            bus  sync_pulse_tracker_if.slave (strobe in, status out)        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module sync_pulse_tracker #(
  parameter int NOM_PERIOD = 16384,
  parameter int NOM_WIDTH  = 8,
  parameter int TOL        = 4,
  parameter int LOCK_COUNT = 3,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  sync_pulse_tracker_if.slave  bus
);

  // --------------------------------------------------------------------------
  // Constants. Lower bounds are clamped at zero so a tolerance larger than the
  // nominal value cannot wrap into a huge unsigned threshold.
  // --------------------------------------------------------------------------
  localparam int GOOD_W     = $clog2(LOCK_COUNT + 1);
  localparam int C_PER_LO_I = (NOM_PERIOD > TOL) ? (NOM_PERIOD - TOL) : 0;
  localparam int C_WID_LO_I = (NOM_WIDTH > TOL) ? (NOM_WIDTH - TOL) : 0;

  localparam logic [CNT_W-1:0]  c_per_lo  = CNT_W'(C_PER_LO_I);
  localparam logic [CNT_W-1:0]  c_per_hi  = CNT_W'(NOM_PERIOD + TOL);
  localparam logic [CNT_W-1:0]  c_timeout = CNT_W'(NOM_PERIOD + TOL + 1);
  localparam logic [CNT_W-1:0]  c_wid_lo  = CNT_W'(C_WID_LO_I);
  localparam logic [CNT_W-1:0]  c_wid_hi  = CNT_W'(NOM_WIDTH + TOL);
  localparam logic [GOOD_W-1:0] c_lock    = GOOD_W'(LOCK_COUNT);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic              r_s1;
  logic              r_s2;
  logic              w_rise;
  logic              w_fall;

  logic [CNT_W-1:0]  r_per_cnt;
  logic [CNT_W-1:0]  r_hi_cnt;
  logic [CNT_W-1:0]  r_period;
  logic [CNT_W-1:0]  r_width;

  logic              w_pgood;
  logic              w_wgood;
  logic              w_timeout;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [GOOD_W-1:0] r_good_cnt;
  logic [GOOD_W-1:0] w_good_nxt;
  logic [GOOD_W-1:0] w_good_inc;
  logic              w_fault;

  logic              r_sync_rise;
  logic              r_locked;
  logic              r_miss_err;
  logic [7:0]        r_err_cnt;

  // --------------------------------------------------------------------------
  // Edge detection. sync_in is already synchronous to clk, so s1/s2 form a
  // plain delay line rather than a metastability synchroniser.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= bus.sync_in;
      r_s2 <= r_s1;
    end
  end

  assign w_rise = r_s1 & ~r_s2;
  assign w_fall = ~r_s1 & r_s2;

  // --------------------------------------------------------------------------
  // Period and width measurement.
  // per_cnt stays parked at 0 until the first rise, which is what keeps the
  // timeout from firing before anything has been seen.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_per_cnt <= '0;
      r_hi_cnt  <= '0;
      r_period  <= '0;
      r_width   <= '0;
    end else begin
      if (w_rise) begin
        r_per_cnt <= CNT_W'(1);
      end else if ((r_per_cnt != '0) && (r_per_cnt != '1)) begin
        r_per_cnt <= r_per_cnt + CNT_W'(1);
      end

      // The first rise out of SEARCH has no valid predecessor to measure from.
      if (w_rise && (r_state != ST_SEARCH)) begin
        r_period <= r_per_cnt;
      end

      if (w_rise) begin
        r_hi_cnt <= CNT_W'(1);
      end else if (r_s1 && (r_hi_cnt != '1)) begin
        r_hi_cnt <= r_hi_cnt + CNT_W'(1);
      end

      if (w_fall) begin
        r_width <= r_hi_cnt;
      end
    end
  end

  assign w_pgood   = (r_per_cnt >= c_per_lo) && (r_per_cnt <= c_per_hi);
  assign w_wgood   = (r_hi_cnt >= c_wid_lo) && (r_hi_cnt <= c_wid_hi);
  // A rise in the same cycle wins: a late rise is judged as a bad period.
  assign w_timeout = (r_per_cnt == c_timeout) && !w_rise && (r_state != ST_SEARCH);

  // --------------------------------------------------------------------------
  // Lock state machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_SEARCH;
      r_good_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_good_cnt <= w_good_nxt;
    end
  end

  assign w_good_inc = r_good_cnt + GOOD_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good_cnt;
    w_fault     = 1'b0;

    unique case (r_state)
      ST_SEARCH: begin
        if (w_rise) begin
          w_state_nxt = ST_ACQUIRE;
          w_good_nxt  = '0;
        end
      end

      ST_ACQUIRE: begin
        if (w_rise) begin
          if (w_pgood) begin
            w_good_nxt = w_good_inc;
            if (w_good_inc == c_lock) begin
              w_state_nxt = ST_LOCKED;
            end
          end else begin
            w_good_nxt = '0;
          end
        end else if (w_timeout) begin
          w_state_nxt = ST_SEARCH;
        end
      end

      ST_LOCKED: begin
        if (w_rise) begin
          if (!w_pgood) begin
            w_state_nxt = ST_ACQUIRE;
            w_good_nxt  = '0;
            w_fault     = 1'b1;
          end
        end else if (w_timeout) begin
          w_state_nxt = ST_SEARCH;
          w_fault     = 1'b1;
        end else if (w_fall && !w_wgood) begin
          // Malformed width is reported but does not break lock.
          w_fault = 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_SEARCH;
        w_good_nxt  = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registered outputs. locked follows the registered state, so it moves one
  // cycle after the edge that changed the state.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync_rise <= 1'b0;
      r_locked    <= 1'b0;
      r_miss_err  <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_sync_rise <= w_rise;
      r_locked    <= (r_state == ST_LOCKED);

      // A fault coinciding with err_clr is kept: the clear only wipes history.
      if (w_fault) begin
        r_miss_err <= 1'b1;
        if (bus.err_clr) begin
          r_err_cnt <= 8'd1;
        end else if (r_err_cnt != 8'hFF) begin
          r_err_cnt <= r_err_cnt + 8'd1;
        end
      end else if (bus.err_clr) begin
        r_miss_err <= 1'b0;
        r_err_cnt  <= '0;
      end
    end
  end

  assign bus.sync_rise = r_sync_rise;
  assign bus.locked    = r_locked;
  assign bus.period    = r_period;
  assign bus.width     = r_width;
  assign bus.miss_err  = r_miss_err;
  assign bus.err_cnt   = r_err_cnt;

endmodule
`default_nettype wire
